// File: rtl/cpu_writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package cpu_writeback_arbiter_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned DATA_W    = 32;

  // One buffered long-latency-unit result.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } lu_result_t;

  // One-hot register mask for rd; r0 is never a real destination, so bit 0 stays clear.
  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    logic [REG_COUNT-1:0] mask;
    mask    = '0;
    mask[rd] = 1'b1;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/cpu_writeback_fifo.sv
// Small synchronous FIFO of LU results with wrap-bit pointers. Besides the head it
// exposes the post-update (next-state) entry view so a registered copy of any mask
// derived from it lines up with the stored contents.
module cpu_writeback_fifo
  import cpu_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  lu_result_t                wdata_i,
  output lu_result_t                rdata_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [DEPTH-1:0]          next_valid_o,
  output logic [DEPTH*RD_W-1:0]     next_rd_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_next;
  lu_result_t  mem_q [DEPTH];
  lu_result_t  mem_d [DEPTH];
  logic        full;
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Next-state entry view: slot i is live when its offset from the new head is below the new count.
  always_comb begin
    logic [AW-1:0] off;
    count_next   = wr_ptr_d - rd_ptr_d;
    next_valid_o = '0;
    next_rd_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = i[AW-1:0] - rd_ptr_d[AW-1:0];
      next_valid_o[i]          = ({1'b0, off} < count_next);
      next_rd_o[i*RD_W +: RD_W] = mem_d[i].rd;
    end
  end

  // Pointer and storage state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/cpu_writeback_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline wins every cycle it has a result,
// buffered long-latency-unit results fill idle slots, and a wait counter forces a one-cycle
// pipeline stall so the buffer head can never starve.
module cpu_writeback_arbiter
  import cpu_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pipe_strobe,
  input  logic [4:0]  i_pipe_rd,
  input  logic [31:0] i_pipe_data,
  output logic        o_pipe_stall,
  input  logic        i_lu_valid,
  output logic        o_lu_ready,
  input  logic [4:0]  i_lu_rd,
  input  logic [31:0] i_lu_data,
  output logic        o_wr_enable,
  output logic [4:0]  o_wr_rd,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_pending,
  output logic [63:0] o_retired
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic                   last_strobe_q;
  logic                   wr_en_q, wr_en_d;
  logic [4:0]             wr_rd_q, wr_rd_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic [63:0]            retired_q, retired_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [REG_COUNT-1:0]   pending_q, pending_d;

  lu_result_t             push_data;
  lu_result_t             head;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [DEPTH-1:0]       next_valid;
  logic [DEPTH*RD_W-1:0]  next_rd;

  logic                   pipe_event;
  logic                   push;
  logic                   pop;
  logic                   grant;
  logic [4:0]             grant_rd;
  logic [31:0]            grant_data;

  assign pipe_event     = i_pipe_strobe ^ last_strobe_q;
  assign o_lu_ready     = (fifo_count != CW'(DEPTH));
  assign push           = i_lu_valid && o_lu_ready;
  assign pop            = !pipe_event && !fifo_empty;
  assign push_data.rd   = i_lu_rd;
  assign push_data.data = i_lu_data;
  assign o_pipe_stall   = (wait_q == WW'(MAX_WAIT));

  assign o_wr_enable = wr_en_q;
  assign o_wr_rd     = wr_rd_q;
  assign o_wr_data   = wr_data_q;
  assign o_retired   = retired_q;
  assign o_pending   = pending_q;

  cpu_writeback_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (i_clock),
    .rst_ni       (i_reset),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (push_data),
    .rdata_o      (head),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .next_valid_o (next_valid),
    .next_rd_o    (next_rd)
  );

  // Grant selection and registered write-port / retire-counter next state.
  always_comb begin
    grant      = pipe_event || pop;
    grant_rd   = pipe_event ? i_pipe_rd : head.rd;
    grant_data = pipe_event ? i_pipe_data : head.data;
    wr_en_d    = grant && (grant_rd != 5'd0);
    wr_rd_d    = grant ? grant_rd : wr_rd_q;
    wr_data_d  = grant ? grant_data : wr_data_q;
    retired_d  = retired_q + 64'(grant);
  end

  // Head-wait counter: resets on pop or empty, saturates at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Pending-rd mask over the post-update FIFO contents.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (next_valid[i]) pending_d = pending_d | rd_onehot(next_rd[i*RD_W +: RD_W]);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      last_strobe_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_rd_q       <= '0;
      wr_data_q     <= '0;
      retired_q     <= '0;
      wait_q        <= '0;
      pending_q     <= '0;
    end else begin
      last_strobe_q <= i_pipe_strobe;
      wr_en_q       <= wr_en_d;
      wr_rd_q       <= wr_rd_d;
      wr_data_q     <= wr_data_d;
      retired_q     <= retired_d;
      wait_q        <= wait_d;
      pending_q     <= pending_d;
    end
  end

  // The pipeline must hold its strobe while stalled; the grant still goes to the pipe if not.
  stall_no_toggle : assert property (
    @(posedge i_clock) disable iff (!i_reset) o_pipe_stall |-> !pipe_event
  );

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
module tb_cpu_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [4:0]  prd;
  logic [31:0] pdata;
  logic        stall;
  logic        luv;
  logic        ready;
  logic [4:0]  lurd;
  logic [31:0] ludata;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic [63:0] retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_writeback_arbiter #(
    .DEPTH    (4),
    .MAX_WAIT (8)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_pipe_strobe (strobe),
    .i_pipe_rd     (prd),
    .i_pipe_data   (pdata),
    .o_pipe_stall  (stall),
    .i_lu_valid    (luv),
    .o_lu_ready    (ready),
    .i_lu_rd       (lurd),
    .i_lu_data     (ludata),
    .o_wr_enable   (wr_en),
    .o_wr_rd       (wr_rd),
    .o_wr_data     (wr_data),
    .o_pending     (pending),
    .o_retired     (retired)
  );

  typedef struct {
    logic        strobe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] ludata;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ready;
    logic        stall;
    logic [31:0] pend;
    logic [63:0] ret;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, input logic [4:0] pr, input logic [31:0] pd,
                              input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic e, input logic [4:0] r, input logic [31:0] d,
                              input logic [31:0] pm, input logic [63:0] rt);
    vec_t v;
    v.strobe = s;  v.prd = pr; v.pdata = pd;
    v.luv = lv;    v.lurd = lr; v.ludata = ld;
    v.en = e;      v.rd = r;    v.data = d;
    v.ready = 1'b1; v.stall = 1'b0; v.pend = pm; v.ret = rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_seen;
    int lu_seen;
    logic [63:0] ret_base;

    // Directed vectors: inputs for one cycle, then outputs expected after that edge.
    vecs[0]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            0,       0);
    vecs[1]  = mk(1, 5, 32'hA5,       0, 0, 0,      1, 5, 32'hA5,       0,       1);
    vecs[2]  = mk(0, 0, 32'hBEEF,     0, 0, 0,      0, 0, 32'hBEEF,     0,       2);
    vecs[3]  = mk(1, 7, 32'h77,       0, 0, 0,      1, 7, 32'h77,       0,       3);
    vecs[4]  = mk(1, 0, 0,            0, 0, 0,      0, 7, 32'h77,       0,       3);
    vecs[5]  = mk(1, 0, 0,            1, 9, 32'h1234, 0, 7, 32'h77,     32'h200, 3);
    vecs[6]  = mk(1, 0, 0,            0, 0, 0,      1, 9, 32'h1234,     0,       4);
    vecs[7]  = mk(1, 0, 0,            0, 0, 0,      0, 9, 32'h1234,     0,       4);
    vecs[8]  = mk(0, 3, 32'h33,       1, 4, 32'h44, 1, 3, 32'h33,       32'h10,  5);
    vecs[9]  = mk(0, 0, 0,            0, 0, 0,      1, 4, 32'h44,       0,       6);
    vecs[10] = mk(0, 0, 0,            0, 0, 0,      0, 4, 32'h44,       0,       6);
    vecs[11] = mk(0, 0, 0,            1, 6, 32'h61, 0, 4, 32'h44,       32'h40,  6);
    vecs[12] = mk(1, 2, 32'h22,       1, 6, 32'h62, 1, 2, 32'h22,       32'h40,  7);
    vecs[13] = mk(1, 0, 0,            0, 0, 0,      1, 6, 32'h61,       32'h40,  8);
    vecs[14] = mk(1, 0, 0,            0, 0, 0,      1, 6, 32'h62,       0,       9);
    vecs[15] = mk(1, 0, 0,            0, 0, 0,      0, 6, 32'h62,       0,       9);

    // Reset with quiet inputs.
    rst_n = 1'b0; strobe = 1'b0; prd = '0; pdata = '0; luv = 1'b0; lurd = '0; ludata = '0;
    tick();
    tick();
    chk("reset wr_en", {63'd0, wr_en}, 64'd0);
    chk("reset wr_rd", {59'd0, wr_rd}, 64'd0);
    chk("reset wr_data", {32'd0, wr_data}, 64'd0);
    chk("reset pending", {32'd0, pending}, 64'd0);
    chk("reset retired", retired, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    #3 rst_n = 1'b1;
    #1 chk("ready after release", {63'd0, ready}, 64'd1);

    for (int i = 0; i < 16; i++) begin
      strobe = vecs[i].strobe; prd = vecs[i].prd; pdata = vecs[i].pdata;
      luv = vecs[i].luv; lurd = vecs[i].lurd; ludata = vecs[i].ludata;
      tick();
      chk($sformatf("row%0d wr_en", i), {63'd0, wr_en}, {63'd0, vecs[i].en});
      chk($sformatf("row%0d wr_rd", i), {59'd0, wr_rd}, {59'd0, vecs[i].rd});
      chk($sformatf("row%0d wr_data", i), {32'd0, wr_data}, {32'd0, vecs[i].data});
      chk($sformatf("row%0d ready", i), {63'd0, ready}, {63'd0, vecs[i].ready});
      chk($sformatf("row%0d stall", i), {63'd0, stall}, {63'd0, vecs[i].stall});
      chk($sformatf("row%0d pending", i), {32'd0, pending}, {32'd0, vecs[i].pend});
      chk($sformatf("row%0d retired", i), retired, vecs[i].ret);
    end
    luv = 1'b0;

    // Starvation: pipe busy every cycle, 4 LU pushes. Head waits 8 cycles, stall, pop, repeat.
    ret_base   = retired;
    stall_seen = 0;
    lu_seen    = 0;
    prd        = 5'd10;
    for (int r = 0; r < 51; r++) begin
      if (!stall) strobe = ~strobe;
      pdata  = 32'hA000_0000 | r;
      luv    = (r < 4);
      lurd   = 5'(r + 1);
      ludata = 32'hC0 + r;
      tick();
      if (r == 3) chk("ready low when full", {63'd0, ready}, 64'd0);
      if (r == 9) chk("ready back after pop", {63'd0, ready}, 64'd1);
      if (stall) begin
        chk($sformatf("stall%0d row", stall_seen), r, 8 + 9 * stall_seen);
        stall_seen++;
      end
      if (wr_en && wr_rd != 5'd10) begin
        chk($sformatf("lu write%0d rd", lu_seen), {59'd0, wr_rd}, lu_seen + 1);
        chk($sformatf("lu write%0d data", lu_seen), {32'd0, wr_data}, 32'hC0 + lu_seen);
        chk($sformatf("lu write%0d row", lu_seen), r, 9 + 9 * lu_seen);
        lu_seen++;
      end
    end
    luv = 1'b0;
    chk("stall count", stall_seen, 4);
    chk("lu write count", lu_seen, 4);
    chk("one grant per cycle", retired, ret_base + 64'd51);
    chk("pending drained", {32'd0, pending}, 64'd0);

    // Async reset with 3 entries buffered behind a busy pipe.
    prd = 5'd20;
    for (int r = 0; r < 3; r++) begin
      strobe = ~strobe;
      pdata  = 32'hDEAD_0000 | r;
      luv    = 1'b1;
      lurd   = 5'(11 + r);
      ludata = 32'hE0 + r;
      tick();
    end
    luv = 1'b0;
    chk("pre-reset pending", {32'd0, pending}, 64'h3800);
    #3 rst_n = 1'b0;
    #1;
    chk("async wr_en", {63'd0, wr_en}, 64'd0);
    chk("async wr_rd", {59'd0, wr_rd}, 64'd0);
    chk("async wr_data", {32'd0, wr_data}, 64'd0);
    chk("async pending", {32'd0, pending}, 64'd0);
    chk("async retired", retired, 64'd0);
    chk("async stall", {63'd0, stall}, 64'd0);
    strobe = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      chk($sformatf("no stale write %0d", r), {63'd0, wr_en}, 64'd0);
    end
    chk("post-reset ready", {63'd0, ready}, 64'd1);
    chk("post-reset pending", {32'd0, pending}, 64'd0);
    chk("post-reset retired", retired, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_writeback_arbiter.md
Name: cpu_writeback_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline (memory-stage result, toggle-strobe handshake) and an out-of-order long-latency unit (LU: divider/multiplier, valid/ready handshake). The pipeline has priority. LU results are buffered in a small FIFO and drained into idle write slots. A starvation counter briefly stalls the pipeline so buffered LU results always drain. It also counts retired writebacks and exports a pending-rd mask for decode hazard checks.

Parameters:
DEPTH, 4, LU result FIFO entries (power of two, >=2)
MAX_WAIT, 8, cycles a non-empty FIFO head may wait before forcing a pipeline stall (>=1)

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-low
i_pipe_strobe  in  1  toggles once per pipeline result
i_pipe_rd  in  5  pipeline destination register
i_pipe_data  in  32  pipeline result
o_pipe_stall  out  1  pipeline must not toggle strobe while high
i_lu_valid  in  1  LU result valid
o_lu_ready  out  1  FIFO not full
i_lu_rd  in  5  LU destination register
i_lu_data  in  32  LU result
o_wr_enable  out  1  register-file write strobe, one cycle
o_wr_rd  out  5  write address
o_wr_data  out  32  write data
o_pending  out  32  bit n set when any FIFO entry targets rd n (bit 0 always 0)
o_retired  out  64  granted writebacks

Behaviour:
- Reset (async, i_reset=0): FIFO empty, wait_cnt=0, last_strobe=0, retired=0. o_wr_enable, o_wr_rd, o_wr_data, o_pending, o_retired and o_pipe_stall are all 0. o_lu_ready=1 after release. Reset mid-operation discards buffered LU results.
- Pipe event: i_pipe_strobe != last_strobe. last_strobe updates every cycle. i_pipe_strobe must be 0 at reset release; a 1 at release counts as an event.
- Grant per cycle:
  - Pipe event: write pipe rd/data.
  - Else, FIFO non-empty: pop head and write it.
  - Else: idle.
- Write outputs are registered, 1-cycle latency from event/pop. o_wr_enable=1 only if the granted rd != 0. o_wr_rd and o_wr_data hold their last values when idle.
- o_retired +1 per grant, including rd=0 grants. At most one grant per cycle. Wraps at 2^64.
- LU push when i_lu_valid & o_lu_ready. No bypass: a pushed entry is poppable from the next cycle, so minimum LU-to-write latency is 2 cycles. Push and pop in the same cycle when full is illegal (ready=0). When not full, both occur and the count is unchanged.
- o_lu_ready = count != DEPTH, combinational from registered count.
- wait_cnt: cleared on pop or when the FIFO is empty. Otherwise increments each cycle the FIFO is non-empty and not popped. Saturates at MAX_WAIT.
- o_pipe_stall = (wait_cnt == MAX_WAIT), combinational from the register. Upstream guarantees no strobe toggle while it is high, so the head pops that cycle and stall lasts exactly one cycle. A toggle during stall is a protocol violation (assert in sim); RTL still grants the pipe.
- o_pending recomputed from valid FIFO entries, registered, so it is updated the cycle after push/pop. Duplicate rds in the FIFO keep the bit set until the last one pops.
- Pointers are clog2(DEPTH)+1 bits with wrap bit. Full/empty are decided by pointer compare.

Decomposition:
- Shared package (CPU_Defines): lu_result_t {rd[4:0], data[31:0]}; REG_COUNT=32.
- Sub-module cpu_writeback_fifo: DEPTH-parametrised synchronous FIFO of lu_result_t with push/pop/full/empty/count and a flat entry-valid view for the pending mask.
- Arbiter logic, the wait counter and the retired counter stay in the top block.

Test Plan:
- Reset release with no stimulus, then 3 pipe toggles with rd=5,0,7 → wr_enable on 1st and 3rd only (rd5, rd7), one cycle after each toggle. o_retired=3.
- FIFO empty; push LU rd=9 data=0x1234 with no pipe activity → wr rd=9 data=0x1234 two cycles after push. o_pending bit 9 set for one cycle then clear.
- Toggle pipe every cycle; push 4 LU results (rd 1..4) → o_lu_ready=0 after the 4th push. o_pipe_stall high at wait_cnt=8, and LU rd1 is written in that stall cycle. Stall recurs every 9 cycles until the FIFO is empty. Writes appear in order 1,2,3,4.
- Same cycle: pipe toggle (rd=3) and LU push (rd=4) into an empty FIFO → rd3 written in cycle N+1, rd4 in N+2. o_retired +2.
- Push rd=6 twice, then pop once → o_pending bit 6 remains 1 until the second pop.
- Assert i_reset mid-burst with 3 entries buffered → all outputs 0 immediately (async). After release: o_lu_ready=1, o_pending=0, and no stale writes appear.
